// File: rtl/gen_reg_file.sv
// gen_reg_file: parametrised general-register file with two registered read
// ports, one write port (full / high-half / low-half), error pulses and a
// sequential clear engine.
// Optional macro GEN_REG_BYPASS_EN: a read that hits the address of an accepted
// same-cycle write returns the post-write value instead of the old contents.
//
// state   | meaning
// S_IDLE  | normal operation, clr_req starts a sweep
// S_CLEAR | zeroing reg[r_idx] each cycle, writes rejected, busy=1

module gen_reg_file #(
   parameter int DATA_W   = 20,
   parameter int NUM_REGS = 6,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_sel,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   input  logic              rd0_en,
   input  logic [1:0]        rd0_sel,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic [DATA_W-1:0] rd0_data,
   output logic              rd0_valid,
   output logic              rd0_err,
   input  logic              rd1_en,
   input  logic [1:0]        rd1_sel,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   output logic              rd1_err,
   input  logic              clr_req,
   output logic              busy
);

   localparam int HALF_W = DATA_W / 2;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt;
   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic              w_wr_ok, w_rd0_ok, w_rd1_ok;
   logic [DATA_W-1:0] w_wr_old, w_wr_new, w_rd0_word, w_rd1_word;

   // Half reads are returned zero-extended in the low half.
   function automatic logic [DATA_W-1:0] f_slice(input logic [DATA_W-1:0] word,
                                                 input logic [1:0] sel);
      case (sel)
         2'b01:   f_slice = {{HALF_W{1'b0}}, word[DATA_W-1:HALF_W]};
         2'b10:   f_slice = {{HALF_W{1'b0}}, word[HALF_W-1:0]};
         default: f_slice = word;
      endcase
   endfunction

   assign busy     = (r_state == S_CLEAR);
   assign w_wr_ok  = wr_en && (int'(wr_addr) < NUM_REGS) && (wr_sel != 2'b11) && !busy;
   assign w_rd0_ok = (int'(rd0_addr) < NUM_REGS) && (rd0_sel != 2'b11);
   assign w_rd1_ok = (int'(rd1_addr) < NUM_REGS) && (rd1_sel != 2'b11);

   // Merge the incoming half with the untouched half of the target register.
   always_comb begin
      w_wr_old = '0;
      if (int'(wr_addr) < NUM_REGS) w_wr_old = r_regs[wr_addr];
      case (wr_sel)
         2'b01:   w_wr_new = {wr_data[HALF_W-1:0], w_wr_old[HALF_W-1:0]};
         2'b10:   w_wr_new = {w_wr_old[DATA_W-1:HALF_W], wr_data[HALF_W-1:0]};
         default: w_wr_new = wr_data;
      endcase
   end

   // Source word for each read port, optionally forwarded from the write.
   always_comb begin
      w_rd0_word = '0;
      w_rd1_word = '0;
      if (w_rd0_ok) w_rd0_word = r_regs[rd0_addr];
      if (w_rd1_ok) w_rd1_word = r_regs[rd1_addr];
`ifdef GEN_REG_BYPASS_EN
      if (w_rd0_ok && w_wr_ok && (rd0_addr == wr_addr)) w_rd0_word = w_wr_new;
      if (w_rd1_ok && w_wr_ok && (rd1_addr == wr_addr)) w_rd1_word = w_wr_new;
`endif
   end

   // Clear FSM state and sweep index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state: one register cleared per cycle, leave after the last one.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (clr_req) begin
               w_state_nxt = S_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         S_CLEAR: begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Register array: sweep has priority, writes cannot be accepted while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (r_state == S_CLEAR) begin
         r_regs[r_idx] <= '0;
      end else if (w_wr_ok) begin
         r_regs[wr_addr] <= w_wr_new;
      end
   end

   // Write rejection pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_err <= 1'b0;
      else        wr_err <= wr_en && !w_wr_ok;
   end

   // Read port 0: registered result, data holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd0_data  <= '0;
         rd0_valid <= 1'b0;
         rd0_err   <= 1'b0;
      end else begin
         rd0_valid <= rd0_en && w_rd0_ok;
         rd0_err   <= rd0_en && !w_rd0_ok;
         if (rd0_en) rd0_data <= w_rd0_ok ? f_slice(w_rd0_word, rd0_sel) : '0;
      end
   end

   // Read port 1: identical to port 0, fully independent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_data  <= '0;
         rd1_valid <= 1'b0;
         rd1_err   <= 1'b0;
      end else begin
         rd1_valid <= rd1_en && w_rd1_ok;
         rd1_err   <= rd1_en && !w_rd1_ok;
         if (rd1_en) rd1_data <= w_rd1_ok ? f_slice(w_rd1_word, rd1_sel) : '0;
      end
   end

endmodule

// File: tb/tb_gen_reg_file.sv
// Testbench for gen_reg_file: directed scenarios plus randomized traffic,
// all checked against a behavioural array model.

module tb_gen_reg_file;

   localparam int DW = 20;
   localparam int HW = 10;
   localparam int N  = 6;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en, rd0_en, rd1_en, clr_req;
   logic [1:0]    wr_sel, rd0_sel, rd1_sel;
   logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
   logic [DW-1:0] wr_data, rd0_data, rd1_data;
   logic          wr_err, rd0_valid, rd0_err, rd1_valid, rd1_err, busy;

   always #5 clk = ~clk;

   gen_reg_file #(.DATA_W(DW), .NUM_REGS(N), .ADDR_W(AW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .rd0_en(rd0_en), .rd0_sel(rd0_sel), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
      .rd0_valid(rd0_valid), .rd0_err(rd0_err),
      .rd1_en(rd1_en), .rd1_sel(rd1_sel), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
      .rd1_valid(rd1_valid), .rd1_err(rd1_err),
      .clr_req(clr_req), .busy(busy)
   );

   int n_chk = 0;
   int n_err = 0;

   // Model state: register contents and number of sweep cycles left.
   logic [DW-1:0] m_regs [N];
   int            m_clr_left;
   logic [DW-1:0] e_rd_data  [2];
   logic          e_rd_valid [2];
   logic          e_rd_err   [2];
   logic          e_wr_err, e_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_view(input logic [DW-1:0] w, input logic [1:0] sel);
      if (sel == 2'b01) return w / (1 << HW);
      if (sel == 2'b10) return w % (1 << HW);
      return w;
   endfunction

   function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                             input logic [1:0] sel);
      logic [DW-1:0] lo;
      lo = d % (1 << HW);
      if (sel == 2'b01) return DW'(lo * (1 << HW) + old % (1 << HW));
      if (sel == 2'b10) return DW'((old / (1 << HW)) * (1 << HW) + lo);
      return d;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_clr_left = 0;
      e_wr_err = 1'b0;
      e_busy   = 1'b0;
      for (int p = 0; p < 2; p++) begin
         e_rd_data[p] = '0; e_rd_valid[p] = 1'b0; e_rd_err[p] = 1'b0;
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_sel = 2'b00; wr_addr = '0; wr_data = '0;
      rd0_en = 1'b0; rd0_sel = 2'b00; rd0_addr = '0;
      rd1_en = 1'b0; rd1_sel = 2'b00; rd1_addr = '0;
      clr_req = 1'b0;
   endtask

   // Predict the edge from the current inputs, advance one clock, compare.
   task automatic step();
      bit            acc;
      logic [DW-1:0] nv, base;
      logic          en [2];
      logic [1:0]    sl [2];
      logic [AW-1:0] ad [2];
      en[0] = rd0_en; sl[0] = rd0_sel; ad[0] = rd0_addr;
      en[1] = rd1_en; sl[1] = rd1_sel; ad[1] = rd1_addr;
      acc = wr_en && (int'(wr_addr) < N) && (wr_sel != 2'b11) && (m_clr_left == 0);
      e_wr_err = wr_en && !acc;
      nv = '0;
      if (int'(wr_addr) < N) nv = m_merge(m_regs[wr_addr], wr_data, wr_sel);
      for (int p = 0; p < 2; p++) begin
         e_rd_valid[p] = 1'b0;
         e_rd_err[p]   = 1'b0;
         if (en[p]) begin
            if ((int'(ad[p]) < N) && (sl[p] != 2'b11)) begin
               base = m_regs[ad[p]];
`ifdef GEN_REG_BYPASS_EN
               if (acc && ad[p] == wr_addr) base = nv;
`endif
               e_rd_data[p]  = m_view(base, sl[p]);
               e_rd_valid[p] = 1'b1;
            end else begin
               e_rd_data[p] = '0;
               e_rd_err[p]  = 1'b1;
            end
         end
      end
      if (acc) m_regs[wr_addr] = nv;
      if (m_clr_left > 0) begin
         m_regs[N - m_clr_left] = '0;
         m_clr_left--;
      end else if (clr_req) begin
         m_clr_left = N;
      end
      e_busy = (m_clr_left > 0);
      @(posedge clk);
      #1;
      chk("wr_err",    32'(wr_err),    32'(e_wr_err));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("rd0_valid", 32'(rd0_valid), 32'(e_rd_valid[0]));
      chk("rd0_err",   32'(rd0_err),   32'(e_rd_err[0]));
      chk("rd0_data",  32'(rd0_data),  32'(e_rd_data[0]));
      chk("rd1_valid", 32'(rd1_valid), 32'(e_rd_valid[1]));
      chk("rd1_err",   32'(rd1_err),   32'(e_rd_err[1]));
      chk("rd1_data",  32'(rd1_data),  32'(e_rd_data[1]));
   endtask

   task automatic wr(input int a, input logic [1:0] s, input logic [DW-1:0] d);
      idle();
      wr_en = 1'b1; wr_addr = AW'(a); wr_sel = s; wr_data = d;
      step();
      idle();
   endtask

   task automatic rd(input logic e0, input int a0, input logic [1:0] s0,
                     input logic e1, input int a1, input logic [1:0] s1);
      idle();
      rd0_en = e0; rd0_addr = AW'(a0); rd0_sel = s0;
      rd1_en = e1; rd1_addr = AW'(a1); rd1_sel = s1;
      step();
      idle();
   endtask

   task automatic chk_all_zero_outputs(input string tag);
      chk({tag, "_busy"},   32'(busy),   0);
      chk({tag, "_wr_err"}, 32'(wr_err), 0);
      chk({tag, "_rd0"},    32'({rd0_valid, rd0_err, rd0_data}), 0);
      chk({tag, "_rd1"},    32'({rd1_valid, rd1_err, rd1_data}), 0);
   endtask

   initial begin
      int cnt;
      idle();
      m_reset();
      rst_n = 1'b0;
      #1;
      chk_all_zero_outputs("reset");
      #12 rst_n = 1'b1;
      @(negedge clk);

      // Full write and read back on port 0.
      wr(2, 2'b00, 20'hABCDE);
      rd(1'b1, 2, 2'b00, 1'b0, 0, 2'b00);
      chk("tp_full_rd", 32'(rd0_data), 32'h0ABCDE);
      chk("tp_full_valid", 32'(rd0_valid), 1);

      // Half writes and half/full reads.
      wr(3, 2'b01, 20'h003FF);
      wr(3, 2'b10, 20'h00155);
      rd(1'b1, 3, 2'b00, 1'b1, 3, 2'b01);
      chk("tp_half_full", 32'(rd0_data), 32'hFFD55);
      chk("tp_half_hi",   32'(rd1_data), 32'h003FF);
      rd(1'b1, 3, 2'b10, 1'b1, 3, 2'b10);
      chk("tp_half_lo0", 32'(rd0_data), 32'h00155);
      chk("tp_half_lo1", 32'(rd1_data), 32'h00155);

      // Rejected writes and reads.
      wr(6, 2'b00, 20'h12345);
      chk("tp_wr_oob", 32'(wr_err), 1);
      wr(2, 2'b11, 20'h54321);
      chk("tp_wr_sel11", 32'(wr_err), 1);
      rd(1'b0, 0, 2'b00, 1'b1, 7, 2'b00);
      chk("tp_rd_oob_err", 32'(rd1_err), 1);
      chk("tp_rd_oob_data", 32'(rd1_data), 0);
      rd(1'b1, 2, 2'b00, 1'b0, 0, 2'b00);
      chk("tp_r2_unchanged", 32'(rd0_data), 32'hABCDE);

      // Clear sweep with a write attempted while busy.
      for (int i = 0; i < N; i++) wr(i, 2'b00, DW'((i + 1) * 20'h11111));
      idle(); clr_req = 1'b1;
      step();
      cnt = busy ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         clr_req = (i == 1);
         if (i == 2) begin wr_en = 1'b1; wr_addr = 3'd5; wr_sel = 2'b00; wr_data = 20'h77777; end
         step();
         if (i == 2) chk("tp_wr_busy", 32'(wr_err), 1);
         if (busy) cnt++;
      end
      chk("tp_busy_cycles", 32'(cnt), 6);
      for (int i = 0; i < N; i++) begin
         rd(1'b1, i, 2'b00, 1'b1, i, 2'b01);
         chk("tp_cleared", 32'(rd0_data), 0);
      end

      // Same-cycle write and read of the same register.
      wr(1, 2'b00, 20'h11111);
      idle();
      wr_en = 1'b1; wr_addr = 3'd1; wr_sel = 2'b00; wr_data = 20'h12345;
      rd0_en = 1'b1; rd0_addr = 3'd1; rd0_sel = 2'b00;
      step();
`ifdef GEN_REG_BYPASS_EN
      chk("tp_rdw", 32'(rd0_data), 32'h12345);
`else
      chk("tp_rdw", 32'(rd0_data), 32'h11111);
`endif
      idle();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         wr_en    = ($urandom_range(0, 2) != 0);
         wr_sel   = 2'($urandom_range(0, 7) < 7 ? $urandom_range(0, 2) : 3);
         wr_addr  = AW'($urandom_range(0, 7));
         wr_data  = DW'($urandom);
         rd0_en   = 1'($urandom);
         rd0_sel  = 2'($urandom);
         rd0_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
         rd1_en   = 1'($urandom);
         rd1_sel  = 2'($urandom);
         rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
         clr_req  = ($urandom_range(0, 39) == 0);
         step();
      end
      idle();
      step();

      // Reset in the third cycle of a clear.
      for (int i = 0; i < N; i++) wr(i, 2'b00, DW'(20'h0F0F0 + i));
      rd(1'b1, 4, 2'b00, 1'b1, 5, 2'b00);
      idle(); clr_req = 1'b1;
      step();
      idle();
      rd0_en = 1'b1; rd0_addr = 3'd5;
      step();
      step();
      idle();
      rst_n = 1'b0;
      #1;
      chk_all_zero_outputs("mid_clr_rst");
      m_reset();
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         rd(1'b1, i, 2'b00, 1'b1, i, 2'b10);
         chk("post_rst_zero", 32'(rd0_data), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
